// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//   Shared constants and types for the 16-bit ALU path.
//   - ALU_WIDTH : default operand/result width
//   - ALU_CNT_W : bit-counter width for the default width
//   - state_e   : serial-unit sequencer states (IDLE/RUN/DONE)
//   - cnt_w()   : counter width for an arbitrary operand width
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int ALU_WIDTH = 16;

  // Counter must index bits 0..w-1; never narrower than one bit.
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int ALU_CNT_W = cnt_w(ALU_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage : alu_pkg

// File: rtl/full_subtractor_1bit.sv
// -----------------------------------------------------------------------------
// full_subtractor_1bit
//   Gate-level 1-bit full subtractor: d = x - y - Bin.
//   Ports:
//     x    in  minuend bit
//     y    in  subtrahend bit
//     Bin  in  borrow in
//     Bout out borrow out
//     d    out difference bit
// -----------------------------------------------------------------------------
module full_subtractor_1bit (
  input  logic x,
  input  logic y,
  input  logic Bin,
  output logic Bout,
  output logic d
);

  logic x_xor_y;
  logic nx_and_y;
  logic eq_and_bin;

  assign x_xor_y    = x ^ y;
  assign d          = x_xor_y ^ Bin;
  // Borrow when x<y outright, or when x==y and a borrow is already pending.
  assign nx_and_y   = ~x & y;
  assign eq_and_bin = ~x_xor_y & Bin;
  assign Bout       = nx_and_y | eq_and_bin;

endmodule : full_subtractor_1bit

// File: rtl/serial_subtractor_16bit.sv
// -----------------------------------------------------------------------------
// serial_subtractor_16bit
//   Bit-serial two's-complement subtractor, diff = a - b, LSB first, one bit
//   per clock through a single full-subtractor cell and a registered borrow.
//   Result and flags update only on the completion edge and hold otherwise.
//   Ports:
//     clk      in   rising-edge clock
//     rst_n    in   asynchronous active-low reset
//     start    in   request, sampled only when not busy
//     a, b     in   operands, captured on the accepting edge
//     busy     out  high while bits are being processed
//     done     out  one-cycle pulse, result/flags valid from this cycle
//     diff     out  a - b modulo 2^WIDTH
//     borrow   out  a < b unsigned
//     overflow out  signed overflow of a - b
//     zero     out  diff == 0
// -----------------------------------------------------------------------------
module serial_subtractor_16bit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow,
  output logic             zero
);

  localparam int CNT_W = (WIDTH == ALU_WIDTH) ? ALU_CNT_W : cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  // Only WIDTH-1 partial bits are stored; the final bit comes straight from
  // the cell on the completion edge.
  logic [WIDTH-2:0] res_q, res_d;
  logic             bin_q, bin_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;

  logic             bit_d;
  logic             bout;
  logic [WIDTH-1:0] res_full;

  full_subtractor_1bit u_fs (
    .x    (a_sh_q[0]),
    .y    (b_sh_q[0]),
    .Bin  (bin_q),
    .Bout (bout),
    .d    (bit_d)
  );

  assign res_full = {bit_d, res_q};

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the
    // case statement can leave one unassigned and infer a latch.
    state_d    = state_q;
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    res_d      = res_q;
    bin_d      = bin_q;
    cnt_d      = cnt_q;
    diff_d     = diff_q;
    borrow_d   = borrow_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          res_d   = '0;
          bin_d   = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        res_d  = res_full[WIDTH-1:1];
        bin_d  = bout;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          diff_d     = res_full;
          borrow_d   = bout;
          // Borrow into the MSB differing from borrow out of it means the
          // signed result left the representable range.
          overflow_d = bin_q ^ bout;
          zero_d     = (res_full == '0);
          state_d    = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  // NOTE: the result and flag registers are cleared by reset too, so an
  // abandoned operation leaves no stale result visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      res_q      <= '0;
      bin_q      <= 1'b0;
      cnt_q      <= '0;
      diff_q     <= '0;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_sh_q     <= a_sh_d;
      b_sh_q     <= b_sh_d;
      res_q      <= res_d;
      bin_q      <= bin_d;
      cnt_q      <= cnt_d;
      diff_q     <= diff_d;
      borrow_q   <= borrow_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign diff     = diff_q;
  assign borrow   = borrow_q;
  assign overflow = overflow_q;
  assign zero     = zero_q;

endmodule : serial_subtractor_16bit

// File: tb/tb_serial_subtractor_16bit.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor_16bit
//   Self-checking bench: directed cases plus random operands, compared
//   against arithmetic reference values computed here.
// -----------------------------------------------------------------------------
module tb_serial_subtractor_16bit;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] diff;
  logic         borrow, overflow, zero;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] held_diff = '0;

  serial_subtractor_16bit #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .borrow   (borrow),
    .overflow (overflow),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Present operands and start, let one edge accept them, then scramble the
  // inputs to show they are not needed after capture.
  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv);
    @(negedge clk);
    start = 1'b1;
    a     = av;
    b     = bv;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
  endtask

  // Count edges after acceptance until done; optionally pulse a stray start
  // (with all-ones operands) while running.
  task automatic wait_done(input int inject_at);
    int edges = 0;
    while (edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
      if (done) break;
      check("busy_run", {31'b0, busy}, 32'd1);
      check("held_diff", {16'b0, diff}, {16'b0, held_diff});
      if (edges == inject_at) begin
        start = 1'b1;
        a     = '1;
        b     = '1;
      end else if (edges == inject_at + 1) begin
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
      end
    end
    check("latency", edges, W);
    check("busy_done", {31'b0, busy}, 32'd0);
  endtask

  task automatic check_result(input logic [W-1:0] av, input logic [W-1:0] bv);
    int      ai, bi, di;
    logic    exp_ovf;
    ai = int'(av);
    bi = int'(bv);
    di = (ai - bi) & 32'hFFFF;
    // Signed overflow: operands of different sign and result sign differs
    // from the minuend's.
    exp_ovf = (av[W-1] != bv[W-1]) && (di[W-1] != av[W-1]);
    check("diff", {16'b0, diff}, di);
    check("borrow", {31'b0, borrow}, {31'b0, (ai < bi)});
    check("overflow", {31'b0, overflow}, {31'b0, exp_ovf});
    check("zero", {31'b0, zero}, {31'b0, (di == 0)});
    held_diff = di[W-1:0];
  endtask

  task automatic done_pulse_ends();
    @(posedge clk);
    #1;
    check("done_pulse", {31'b0, done}, 32'd0);
  endtask

  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv);
    start_op(av, bv);
    wait_done(-1);
    check_result(av, bv);
    done_pulse_ends();
  endtask

  initial begin
    int dones;
    logic [W-1:0] ra, rb;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_diff", {16'b0, diff}, 32'd0);
    check("rst_flags", {29'b0, borrow, overflow, zero}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed arithmetic cases.
    run_op(16'h0005, 16'h0003);
    run_op(16'h0000, 16'h0001);
    run_op(16'h8000, 16'h0001);
    run_op(16'h7FFF, 16'hFFFF);
    run_op(16'h1234, 16'h1234);

    // Stray start during RUN is ignored, then a back-to-back accept in DONE.
    start_op(16'h0010, 16'h0001);
    wait_done(5);
    check_result(16'h0010, 16'h0001);
    start = 1'b1;
    a     = 16'h0003;
    b     = 16'h0005;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    check("b2b_busy", {31'b0, busy}, 32'd1);
    check("b2b_no_done", {31'b0, done}, 32'd0);
    wait_done(-1);
    check_result(16'h0003, 16'h0005);
    done_pulse_ends();

    // Random operands, with some equal pairs to hit the zero flag.
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
      run_op(ra, rb);
    end

    // Reset in the middle of RUN.
    start_op(16'hBEEF, 16'h0101);
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_done", {31'b0, done}, 32'd0);
    check("mid_rst_diff", {16'b0, diff}, 32'd0);
    check("mid_rst_flags", {29'b0, borrow, overflow, zero}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    held_diff = '0;
    dones = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    check("no_done_after_rst", dones, 0);
    check("idle_busy", {31'b0, busy}, 32'd0);
    run_op(16'h0009, 16'h0004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_serial_subtractor_16bit
